board_entity_map: RTL and testbench
===================================

// Module: board_entity_map
// PURPOSE
//  Holds the snake-game board as a grid of 2-bit entity codes, one per 16x16-pixel square.
//  Game logic writes cells through a req/ack port.
//  The VGA side supplies pixel coordinates and gets back the entity code for the square
//  under that pixel, with the coordinates delayed to stay aligned.
//  Sits directly upstream of the VGA pattern/sprite stage and drives its ent input.
// PARAMETERS
//  H_SQUARE  16   pixels per square, horizontal; power of two
//  V_SQUARE  16   pixels per square, vertical; power of two
//  GRID_W    40   squares per row (640/H_SQUARE)
//  GRID_H    30   squares per column (480/V_SQUARE)
//  H_ACTIVE  640  visible pixels per line
//  V_ACTIVE  480  visible lines
// PORTS
//  iVGA_CLK   in   1   pixel clock; all logic on posedge
//  reset      in   1   asynchronous, active-high
//  iVGA_X     in   10  current pixel X
//  iVGA_Y     in   10  current pixel Y
//  oVGA_X     out  10  iVGA_X delayed 1 cycle, aligned with oEnt
//  oVGA_Y     out  10  iVGA_Y delayed 1 cycle, aligned with oEnt
//  oEnt       out  2   entity code for the square under (oVGA_X, oVGA_Y)
//  iWr_req    in   1   write request; held high until oWr_ack
//  iWr_col    in   6   target column, 0..GRID_W-1
//  iWr_row    in   5   target row, 0..GRID_H-1
//  iWr_ent    in   2   code to store
//  oWr_ack    out  1   1-cycle pulse: request consumed
//  oWr_err    out  1   1-cycle pulse with oWr_ack: coordinate out of range, write dropped
//  iClr       in   1   1-cycle pulse: clear whole board to ENT_NOTHING
//  oBusy      out  1   high while a clear sweep runs
// BEHAVIOUR
//  Entity codes: 0 = head, 1 = body, 2 = apple, 3 = ENT_NOTHING.
//  Reset values: oEnt = 3; oVGA_X = 0; oVGA_Y = 0; oWr_ack = 0; oWr_err = 0; oBusy = 1;
//    FSM = S_CLEAR; sweep address = 0.
//  FSM state S_CLEAR
//    - Writes ENT_NOTHING to address clr_addr each cycle, clr_addr = 0..GRID_W*GRID_H-1 (1200 cycles).
//    - On the last address, moves to S_RUN and oBusy falls on that same edge.
//  FSM state S_RUN
//    - oBusy = 0.
//    - iClr -> S_CLEAR with clr_addr = 0 and oBusy = 1 on the next edge.
//  iClr in S_CLEAR restarts the sweep at address 0.
//  Reset mid-sweep also restarts the sweep from address 0.
//  Write port
//    - Accepted in S_RUN when iWr_req & ~oWr_ack & ~iClr.
//    - On acceptance, the RAM write and oWr_ack = 1 happen on the same edge.
//    - A request still high during the ack cycle is not re-accepted.
//    - Maximum rate is one write per 2 cycles.
//  Out-of-range write (col >= GRID_W or row >= GRID_H)
//    - Acked, with oWr_err = 1; RAM unchanged.
//  A request pending during S_CLEAR, or coincident with iClr
//    - Not acked; stays pending until S_RUN.
//    - Clear always wins.
//  Address arithmetic
//    - addr = row*GRID_W + col, 11 bits.
//    - row = Y >> log2(V_SQUARE), col = X >> log2(H_SQUARE).
//  Read path latency: exactly 1 cycle. oEnt, oVGA_X and oVGA_Y are registered together.
//  oEnt is forced to 3 in any of these cases:
//    - iVGA_X >= H_ACTIVE;
//    - iVGA_Y >= V_ACTIVE;
//    - oBusy was 1 in the sampling cycle.
//  Same-cell read and write on the same edge returns the OLD value.
//    The new value is visible from the next read.
// STRUCTURE
//  Shared header (define.vh): H_SQUARE, V_SQUARE, GRID_W, GRID_H, ENT_* codes, ADDR_W = 11.
//  Sub-module board_ram
//    - Simple dual-port RAM, GRID_W*GRID_H x 2 bits.
//    - One sync write port, muxed between sweep and game write.
//    - One sync read port with registered output.
//  Top level holds the FSM, write arbitration and the read-side address/alignment registers.
// TESTING
//  1. Release reset -> oBusy high for exactly 1200 cycles, then low.
//     A scan of all (x<640, y<480) returns oEnt = 3.
//  2. Write col 5, row 3, ent 0 -> oWr_ack pulse and oWr_err = 0.
//     Pixels x=80..95, y=48..63 then read oEnt = 0 one cycle later; x=96, y=48 reads 3.
//  3. Write col 40, row 0, ent 2 -> oWr_ack and oWr_err pulse together.
//     The full-board scan is unchanged.
//  4. iWr_req held while iClr pulses -> no ack until oBusy falls, then ack within 1 cycle.
//     The cell holds the written value; all other cells read 3.
//  5. iVGA_X = 700, iVGA_Y = 10 -> oEnt = 3 and oVGA_X = 700 one cycle later.
//  6. Assert reset at sweep address 600 -> sweep restarts at 0.
//     oBusy stays high 1200 cycles after release.

Source files
------------

// File: rtl/board_entity_map_pkg.sv
// Shared board geometry, entity codes and the cell address helper.
package board_entity_map_pkg;

    localparam int H_SQUARE = 16;
    localparam int V_SQUARE = 16;
    localparam int H_SHIFT  = $clog2(H_SQUARE);
    localparam int V_SHIFT  = $clog2(V_SQUARE);

    localparam logic [5:0] GRID_W = 6'd40;
    localparam logic [4:0] GRID_H = 5'd30;

    localparam logic [9:0] H_ACTIVE = 10'd640;
    localparam logic [9:0] V_ACTIVE = 10'd480;

    localparam int ADDR_W = 11;
    localparam int CELLS  = int'(GRID_W) * int'(GRID_H);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

    typedef enum logic [1:0] {
        ENT_HEAD    = 2'd0,
        ENT_BODY    = 2'd1,
        ENT_APPLE   = 2'd2,
        ENT_NOTHING = 2'd3
    } ent_t;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    // Row-major cell index: row*GRID_W + col.
    function automatic logic [ADDR_W-1:0] cellAddr(input logic [5:0] row, input logic [5:0] col);
        return ADDR_W'(row) * ADDR_W'(GRID_W) + ADDR_W'(col);
    endfunction

endpackage

// File: rtl/board_entity_map_ram.sv
// Simple dual-port board RAM, one 2-bit entity per cell.
// Sync write; sync read with a registered, maskable output (old data on same-cell collision).
module board_entity_map_ram
    import board_entity_map_pkg::*;
(
    input  logic              iVGA_CLK,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [1:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              rdMask,
    output logic [1:0]        rdata
);

    logic [1:0] mem [CELLS];

    always_ff @(posedge iVGA_CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Masked reads never touch the array, so off-screen pixels cost nothing here.
    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            rdata <= ENT_NOTHING;
        end else if (rdMask) begin
            rdata <= ENT_NOTHING;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/board_entity_map.sv
// Snake board store: game-side req/ack cell writes, VGA-side 1-cycle entity lookup.
// Clear sweep of 1200 cycles after reset or iClr; writes wait while it runs.
module board_entity_map
    import board_entity_map_pkg::*;
(
    input  logic       iVGA_CLK,
    input  logic       reset,
    input  logic [9:0] iVGA_X,
    input  logic [9:0] iVGA_Y,
    output logic [9:0] oVGA_X,
    output logic [9:0] oVGA_Y,
    output logic [1:0] oEnt,
    input  logic       iWr_req,
    input  logic [5:0] iWr_col,
    input  logic [4:0] iWr_row,
    input  logic [1:0] iWr_ent,
    output logic       oWr_ack,
    output logic       oWr_err,
    input  logic       iClr,
    output logic       oBusy
);

    state_t            state;
    logic [ADDR_W-1:0] clrAddr;

    logic              wrAccept;
    logic              wrInRange;
    logic              ramWe;
    logic [ADDR_W-1:0] ramWaddr;
    logic [1:0]        ramWdata;

    logic [5:0]        vgaCol;
    logic [5:0]        vgaRow;
    logic              rdMask;
    logic [ADDR_W-1:0] rdAddr;

    // The ack register doubles as the rate limiter: no acceptance during an ack cycle.
    assign wrAccept  = (state == S_RUN) & iWr_req & ~oWr_ack & ~iClr;
    assign wrInRange = (iWr_col < GRID_W) & (iWr_row < GRID_H);

    always_comb begin
        ramWe    = 1'b0;
        ramWaddr = '0;
        ramWdata = ENT_NOTHING;
        if (state == S_CLEAR) begin
            ramWe    = 1'b1;
            ramWaddr = clrAddr;
        end else if (wrAccept && wrInRange) begin
            ramWe    = 1'b1;
            ramWaddr = cellAddr({1'b0, iWr_row}, iWr_col);
            ramWdata = iWr_ent;
        end
    end

    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            state   <= S_CLEAR;
            clrAddr <= '0;
            oBusy   <= 1'b1;
            oWr_ack <= 1'b0;
            oWr_err <= 1'b0;
        end else begin
            oWr_ack <= wrAccept;
            oWr_err <= wrAccept & ~wrInRange;
            case (state)
                S_CLEAR: begin
                    if (iClr) begin
                        clrAddr <= '0;
                    end else if (clrAddr == LAST_ADDR) begin
                        state   <= S_RUN;
                        oBusy   <= 1'b0;
                        clrAddr <= '0;
                    end else begin
                        clrAddr <= clrAddr + 1'b1;
                    end
                end
                S_RUN: begin
                    if (iClr) begin
                        state   <= S_CLEAR;
                        clrAddr <= '0;
                        oBusy   <= 1'b1;
                    end
                end
                default: begin
                    state <= S_CLEAR;
                    oBusy <= 1'b1;
                end
            endcase
        end
    end

    assign vgaCol = 6'(iVGA_X >> H_SHIFT);
    assign vgaRow = 6'(iVGA_Y >> V_SHIFT);
    assign rdMask = (iVGA_X >= H_ACTIVE) | (iVGA_Y >= V_ACTIVE) | oBusy;
    assign rdAddr = ((iVGA_X >= H_ACTIVE) | (iVGA_Y >= V_ACTIVE)) ? '0 : cellAddr(vgaRow, vgaCol);

    // Coordinates registered on the same edge as the RAM read so they stay aligned with oEnt.
    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            oVGA_X <= '0;
            oVGA_Y <= '0;
        end else begin
            oVGA_X <= iVGA_X;
            oVGA_Y <= iVGA_Y;
        end
    end

    board_entity_map_ram uBoardRam (
        .iVGA_CLK (iVGA_CLK),
        .reset    (reset),
        .we       (ramWe),
        .waddr    (ramWaddr),
        .wdata    (ramWdata),
        .raddr    (rdAddr),
        .rdMask   (rdMask),
        .rdata    (oEnt)
    );

endmodule

// File: tb/tb_board_entity_map.sv
// Directed bench for board_entity_map with a reference board model and a read scoreboard.
module tb_board_entity_map;

    logic       iVGA_CLK = 1'b0;
    logic       reset    = 1'b1;
    logic [9:0] iVGA_X   = '0;
    logic [9:0] iVGA_Y   = '0;
    logic [9:0] oVGA_X;
    logic [9:0] oVGA_Y;
    logic [1:0] oEnt;
    logic       iWr_req  = 1'b0;
    logic [5:0] iWr_col  = '0;
    logic [4:0] iWr_row  = '0;
    logic [1:0] iWr_ent  = '0;
    logic       oWr_ack;
    logic       oWr_err;
    logic       iClr     = 1'b0;
    logic       oBusy;

    int checks = 0;
    int errors = 0;

    logic [1:0]  model [1200];
    logic [21:0] sbq [$];

    board_entity_map dut (
        .iVGA_CLK (iVGA_CLK),
        .reset    (reset),
        .iVGA_X   (iVGA_X),
        .iVGA_Y   (iVGA_Y),
        .oVGA_X   (oVGA_X),
        .oVGA_Y   (oVGA_Y),
        .oEnt     (oEnt),
        .iWr_req  (iWr_req),
        .iWr_col  (iWr_col),
        .iWr_row  (iWr_row),
        .iWr_ent  (iWr_ent),
        .oWr_ack  (oWr_ack),
        .oWr_err  (oWr_err),
        .iClr     (iClr),
        .oBusy    (oBusy)
    );

    always #5 iVGA_CLK = ~iVGA_CLK;

    initial begin
        #800000;
        $display("FAIL watchdog observed timeout expected finish checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < 1200; i++) model[i] = 2'd3;
    endtask

    function automatic logic [1:0] expEnt(input int x, input int y);
        if (x >= 640 || y >= 480) return 2'd3;
        return model[(y / 16) * 40 + (x / 16)];
    endfunction

    // Drive one pixel now (at a negedge), compare it one cycle later.
    task automatic readPix(input int x, input int y);
        logic [21:0] e;
        iVGA_X = 10'(x);
        iVGA_Y = 10'(y);
        sbq.push_back({10'(x), 10'(y), expEnt(x, y)});
        @(negedge iVGA_CLK);
        e = sbq.pop_front();
        check("pix", {10'b0, oVGA_X, oVGA_Y, oEnt}, {10'b0, e});
    endtask

    task automatic scanBoard();
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 40; c++)
                readPix(c * 16 + int'($urandom_range(0, 15)), r * 16 + int'($urandom_range(0, 15)));
    endtask

    // Called at the first negedge where oBusy should be high; returns high-sample count.
    task automatic countBusy(output int n, output bit sawAck);
        n = 0;
        sawAck = 1'b0;
        while (oBusy === 1'b1 && n < 1500) begin
            if (oWr_ack === 1'b1) sawAck = 1'b1;
            n++;
            @(negedge iVGA_CLK);
        end
    endtask

    task automatic doWrite(input int col, input int row, input logic [1:0] ent, input logic expErr);
        int waitN;
        waitN   = 0;
        iWr_req = 1'b1;
        iWr_col = 6'(col);
        iWr_row = 5'(row);
        iWr_ent = ent;
        @(negedge iVGA_CLK);
        while (oWr_ack !== 1'b1 && waitN < 20) begin
            waitN++;
            @(negedge iVGA_CLK);
        end
        check("wr_ack", {31'b0, oWr_ack}, 32'd1);
        check("wr_err", {31'b0, oWr_err}, {31'b0, expErr});
        iWr_req = 1'b0;
        if (!expErr) model[row * 40 + col] = ent;
        @(negedge iVGA_CLK);
        check("wr_ack_drop", {31'b0, oWr_ack}, 32'd0);
    endtask

    task automatic pulseClr();
        iClr = 1'b1;
        @(negedge iVGA_CLK);
        iClr = 1'b0;
        clearModel();
    endtask

    initial begin
        int  n;
        bit  sawAck;
        clearModel();

        // Reset state
        @(negedge iVGA_CLK);
        @(negedge iVGA_CLK);
        check("rst_ent", {30'b0, oEnt}, 32'd3);
        check("rst_x", {22'b0, oVGA_X}, 32'd0);
        check("rst_y", {22'b0, oVGA_Y}, 32'd0);
        check("rst_ack", {31'b0, oWr_ack}, 32'd0);
        check("rst_err", {31'b0, oWr_err}, 32'd0);
        check("rst_busy", {31'b0, oBusy}, 32'd1);

        // 1: initial sweep length and blank board
        reset = 1'b0;
        countBusy(n, sawAck);
        check("sweep_len", n, 32'd1200);
        check("busy_low", {31'b0, oBusy}, 32'd0);
        scanBoard();

        // 2: in-range write, square edges, neighbour
        doWrite(5, 3, 2'd0, 1'b0);
        for (int x = 78; x <= 97; x++) readPix(x, 48);
        for (int y = 46; y <= 65; y++) readPix(85, y);
        readPix(96, 48);

        // Same-cell read/write collision, held request re-accepted only every other cycle
        iVGA_X  = 10'd80;
        iVGA_Y  = 10'd48;
        iWr_req = 1'b1;
        iWr_col = 6'd5;
        iWr_row = 5'd3;
        iWr_ent = 2'd1;
        @(negedge iVGA_CLK);
        check("coll_ack", {31'b0, oWr_ack}, 32'd1);
        check("coll_old", {30'b0, oEnt}, 32'd0);
        @(negedge iVGA_CLK);
        check("held_noack", {31'b0, oWr_ack}, 32'd0);
        check("coll_new", {30'b0, oEnt}, 32'd1);
        @(negedge iVGA_CLK);
        check("held_reack", {31'b0, oWr_ack}, 32'd1);
        iWr_req = 1'b0;
        model[3 * 40 + 5] = 2'd1;
        @(negedge iVGA_CLK);
        check("held_drop", {31'b0, oWr_ack}, 32'd0);
        scanBoard();

        // 3: out-of-range writes are acked with error and dropped
        doWrite(40, 0, 2'd2, 1'b1);
        doWrite(0, 30, 2'd2, 1'b1);
        doWrite(63, 31, 2'd0, 1'b1);
        scanBoard();

        // 4: request coincident with clear waits for the sweep
        iWr_req = 1'b1;
        iWr_col = 6'd7;
        iWr_row = 5'd2;
        iWr_ent = 2'd2;
        pulseClr();
        check("clr_noack", {31'b0, oWr_ack}, 32'd0);
        countBusy(n, sawAck);
        check("clr_sweep_len", n, 32'd1200);
        check("clr_ack_early", {31'b0, sawAck}, 32'd0);
        @(negedge iVGA_CLK);
        check("pend_ack", {31'b0, oWr_ack}, 32'd1);
        check("pend_err", {31'b0, oWr_err}, 32'd0);
        iWr_req = 1'b0;
        model[2 * 40 + 7] = 2'd2;
        @(negedge iVGA_CLK);
        scanBoard();

        // 5: off-screen coordinates and the last visible pixel
        doWrite(39, 29, 2'd2, 1'b0);
        readPix(639, 479);
        readPix(700, 10);
        readPix(640, 0);
        readPix(10, 480);
        readPix(1023, 1023);
        readPix(0, 0);

        // iClr mid-sweep restarts the count
        pulseClr();
        repeat (300) @(negedge iVGA_CLK);
        pulseClr();
        countBusy(n, sawAck);
        check("restart_len", n, 32'd1200);

        // 6: reset at sweep address 600
        doWrite(10, 10, 2'd0, 1'b0);
        pulseClr();
        repeat (600) @(negedge iVGA_CLK);
        check("mid_busy", {31'b0, oBusy}, 32'd1);
        reset = 1'b1;
        @(negedge iVGA_CLK);
        @(negedge iVGA_CLK);
        check("mid_rst_busy", {31'b0, oBusy}, 32'd1);
        check("mid_rst_ent", {30'b0, oEnt}, 32'd3);
        reset = 1'b0;
        countBusy(n, sawAck);
        check("rst_sweep_len", n, 32'd1200);
        clearModel();
        scanBoard();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
